// File: rtl/uart_cmd_bridge.sv
// UART command front-end: receives 8N1 bytes, decodes 1-byte reads and 2-byte writes,
// and masters the GPIO register bus (addr/wdata/we/re) with registered strobes.
`timescale 1ns/1ps
module uart_cmd_bridge #(
   parameter int CLKS_PER_BIT = 16,
   parameter int TIMEOUT_BITS = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [3:0] bus_addr,
   output logic [7:0] bus_wdata,
   output logic       bus_we,
   output logic       bus_re,
   input  logic [7:0] bus_rdata,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       frame_err,
   output logic       cmd_err
);

   localparam int CNT_W     = $clog2(CLKS_PER_BIT);
   localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TO_W      = $clog2(TO_CYCLES + 1);

   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [TO_W-1:0]  TO_LOAD = TO_W'(TO_CYCLES - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
   typedef enum logic {P_HDR, P_WDAT} p_state_e;

   logic             rx_meta_q, rx_meta_d;
   logic             rx_sync_q, rx_sync_d;
   logic             rx_prev_q, rx_prev_d;
   rx_state_e        rx_state_q, rx_state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   p_state_e         p_state_q, p_state_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic [3:0]       bus_addr_q, bus_addr_d;
   logic [7:0]       bus_wdata_q, bus_wdata_d;
   logic             bus_we_q, bus_we_d;
   logic             bus_re_q, bus_re_d;
   logic [7:0]       rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;
   logic             frame_err_q, frame_err_d;
   logic             cmd_err_q, cmd_err_d;
   logic             byte_done;

   // Receiver. byte_done is combinational in the stop-sample cycle so the
   // parser's registered strobes appear exactly one cycle later.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      rx_meta_d   = rx;
      rx_sync_d   = rx_meta_q;
      rx_prev_d   = rx_sync_q;
      rx_state_d  = rx_state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      byte_done   = 1'b0;
      frame_err_d = 1'b0;
      unique case (rx_state_q)
         RX_IDLE: begin
            if (rx_prev_q && !rx_sync_q) begin
               rx_state_d = RX_START;
               cnt_d      = '0;
               bit_idx_d  = '0;
            end
         end
         RX_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d      = '0;
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RX_DATA: begin
            if (cnt_q == BIT_M1) begin
               cnt_d     = '0;
               shift_d   = {rx_sync_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RX_STOP: begin
            if (cnt_q == BIT_M1) begin
               cnt_d      = '0;
               rx_state_d = RX_IDLE;
               if (rx_sync_q) byte_done   = 1'b1;
               else           frame_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // Command parser. A byte arriving in the same cycle the timeout expires wins.
   always_comb begin
      p_state_d   = p_state_q;
      to_cnt_d    = to_cnt_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_we_d    = 1'b0;
      bus_re_d    = 1'b0;
      cmd_err_d   = 1'b0;
      rd_data_d   = bus_re_q ? bus_rdata : rd_data_q;
      rd_valid_d  = bus_re_q;
      if (frame_err_d) begin
         p_state_d = P_HDR;
      end else begin
         unique case (p_state_q)
            P_HDR: begin
               if (byte_done) begin
                  if (shift_q[6:4] != 3'd0) begin
                     cmd_err_d = 1'b1;
                  end else if (shift_q[7]) begin
                     bus_addr_d = shift_q[3:0];
                     to_cnt_d   = TO_LOAD;
                     p_state_d  = P_WDAT;
                  end else begin
                     bus_addr_d = shift_q[3:0];
                     bus_re_d   = 1'b1;
                  end
               end
            end
            P_WDAT: begin
               if (byte_done) begin
                  bus_wdata_d = shift_q;
                  bus_we_d    = 1'b1;
                  p_state_d   = P_HDR;
               end else if (to_cnt_q == '0) begin
                  cmd_err_d = 1'b1;
                  p_state_d = P_HDR;
               end else begin
                  to_cnt_d = to_cnt_q - TO_W'(1);
               end
            end
            default: p_state_d = P_HDR;
         endcase
      end
   end

   // Synchroniser presets to idle-high so reset release never looks like a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
         rx_meta_q   <= 1'b1;
         rx_sync_q   <= 1'b1;
         rx_prev_q   <= 1'b1;
         rx_state_q  <= RX_IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         p_state_q   <= P_HDR;
         to_cnt_q    <= '0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_we_q    <= 1'b0;
         bus_re_q    <= 1'b0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         cmd_err_q   <= 1'b0;
      end else begin
         rx_meta_q   <= rx_meta_d;
         rx_sync_q   <= rx_sync_d;
         rx_prev_q   <= rx_prev_d;
         rx_state_q  <= rx_state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         p_state_q   <= p_state_d;
         to_cnt_q    <= to_cnt_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_we_q    <= bus_we_d;
         bus_re_q    <= bus_re_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         frame_err_q <= frame_err_d;
         cmd_err_q   <= cmd_err_d;
      end
   end

   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign bus_we    = bus_we_q;
   assign bus_re    = bus_re_q;
   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;
   assign frame_err = frame_err_q;
   assign cmd_err   = cmd_err_q;

endmodule
